// File: rtl/adc_sampler.sv
// ---------------------------------------------------------------------------
// adc_sampler
//
// Periodically reads one byte from a serial ADC. A free-running tick counter
// produces a one-cycle tick every SAMPLE_DIV clocks. A tick that arrives while
// idle and enabled starts a conversion: chip select drops, a setup delay runs,
// then eight serial-clock pulses are driven, and one data bit is captured on
// the first clock cycle of each high phase, MSB first. When the conversion
// ends, chip select is released and the byte is presented together with a
// one-cycle valid strobe. A tick that arrives while a conversion is in flight
// is dropped and reported on overrun.
//
// Optional feature (macro ADC_AVG_EN): four consecutive conversions are
// summed, and the mean of the four is presented with a single strobe.
//
// Parameters
//   CLK_DIV     clk cycles per adc_sclk half-period        (1..255)
//   CS_SETUP    clk cycles from adc_cs_n low to first rise (1..1023)
//   SAMPLE_DIV  clk cycles per sample tick
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous active-high reset
//   en        in   conversions enabled while high
//   adc_cs_n  out  ADC chip select, active low
//   adc_sclk  out  ADC serial clock, idle low
//   adc_sdo   in   ADC serial data, MSB first
//   odata     out  latest sample, held between strobes
//   o_flag    out  one-cycle strobe marking odata valid
//   overrun   out  one-cycle pulse when a tick hits a busy conversion
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cs_n high, waiting for a tick with en high
// S_SETUP | cs_n low, counting down the chip-select setup time
// S_SHIFT | generating 8 sclk pulses, capturing sdo on each rise
// S_DONE  | last sclk fall visible; result, strobe and cs_n release load
// ---------------------------------------------------------------------------
module adc_sampler #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned CS_SETUP   = 100,
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       en,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_sdo,
  output logic [7:0] odata,
  output logic       o_flag,
  output logic       overrun
);

  localparam int unsigned TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [9:0]        SETUP_LOAD = 10'(CS_SETUP - 1);
  localparam logic [9:0]        HALF_LOAD  = 10'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Sample tick: free-running, independent of en and of the FSM
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Conversion FSM and its datapath registers
  // -------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_tmr;
  logic [9:0] w_tmr_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       r_cs_n;
  logic       w_cs_n_nxt;
  logic       r_sclk;
  logic       w_sclk_nxt;
  logic [7:0] r_odata;
  logic [7:0] w_odata_nxt;
  logic       r_flag;
  logic       w_flag_nxt;
  logic       r_ovr;
  logic       w_ovr_nxt;

`ifdef ADC_AVG_EN
  logic [9:0] r_acc;
  logic [9:0] w_acc_nxt;
  logic [9:0] w_acc_sum;
  logic [1:0] r_avg_cnt;
  logic [1:0] w_avg_cnt_nxt;

  // Four 8-bit samples sum to at most 1020, so 10 bits never overflow.
  assign w_acc_sum = r_acc + {2'b00, r_shift};
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_odata   <= '0;
      r_flag    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef ADC_AVG_EN
      r_acc     <= '0;
      r_avg_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_odata   <= w_odata_nxt;
      r_flag    <= w_flag_nxt;
      r_ovr     <= w_ovr_nxt;
`ifdef ADC_AVG_EN
      r_acc     <= w_acc_nxt;
      r_avg_cnt <= w_avg_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_cs_n_nxt    = r_cs_n;
    w_sclk_nxt    = r_sclk;
    w_odata_nxt   = r_odata;
    w_flag_nxt    = 1'b0;
    w_ovr_nxt     = 1'b0;
`ifdef ADC_AVG_EN
    w_acc_nxt     = r_acc;
    w_avg_cnt_nxt = r_avg_cnt;
`endif

    // Any tick outside IDLE is dropped; DONE counts as busy.
    if (w_tick && (r_state != S_IDLE)) begin
      w_ovr_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_cs_n_nxt = 1'b1;
        w_sclk_nxt = 1'b0;
        if (w_tick && en) begin
          w_state_nxt = S_SETUP;
          w_cs_n_nxt  = 1'b0;
          w_tmr_nxt   = SETUP_LOAD;
        end
      end

      S_SETUP: begin
        if (r_tmr == '0) begin
          w_state_nxt   = S_SHIFT;
          w_sclk_nxt    = 1'b1;
          w_tmr_nxt     = HALF_LOAD;
          w_bit_cnt_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr - 10'd1;
        end
      end

      S_SHIFT: begin
        // First cycle of a high phase is the cycle sclk rose.
        if (r_sclk && (r_tmr == HALF_LOAD)) begin
          w_shift_nxt = {r_shift[6:0], adc_sdo};
        end
        if (r_tmr == '0) begin
          w_tmr_nxt = HALF_LOAD;
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = S_DONE;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_sclk_nxt = 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr - 10'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
`ifdef ADC_AVG_EN
        if (r_avg_cnt == 2'd3) begin
          w_odata_nxt   = w_acc_sum[9:2];
          w_flag_nxt    = 1'b1;
          w_acc_nxt     = '0;
          w_avg_cnt_nxt = '0;
        end else begin
          w_acc_nxt     = w_acc_sum;
          w_avg_cnt_nxt = r_avg_cnt + 2'd1;
        end
`else
        w_odata_nxt = r_shift;
        w_flag_nxt  = 1'b1;
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
      end
    endcase

`ifdef ADC_AVG_EN
    // Disabling restarts the averaging window; a conversion finishing
    // while disabled contributes nothing.
    if (!en) begin
      w_acc_nxt     = '0;
      w_avg_cnt_nxt = '0;
      w_flag_nxt    = 1'b0;
      w_odata_nxt   = r_odata;
    end
`endif
  end

  assign adc_cs_n = r_cs_n;
  assign adc_sclk = r_sclk;
  assign odata    = r_odata;
  assign o_flag   = r_flag;
  assign overrun  = r_ovr;

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter CLK_DIV, default 25: Clk cycles per adc_sclk half-period; legal range 1..255.
REQ-002 Parameter CS_SETUP, default 100: Clk cycles from adc_cs_n falling to the first adc_sclk rise; legal range 1..1023.
REQ-003 Parameter SAMPLE_DIV, default 50000: Clk cycles per sample tick; must exceed CS_SETUP+16*CLK_DIV+2.
REQ-004 Clk  input  1  system clock; sole clock, all logic on rising edge.
REQ-005 Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 en  input  1  conversions enabled while high.
REQ-007 adc_cs_n  output  1  ADC chip select, active low.
REQ-008 adc_sclk  output  1  ADC serial clock, idle low.
REQ-009 adc_sdo  input  1  ADC serial data, MSB first.
REQ-010 odata  output  8  latest sample; feeds the filter chain idata.
REQ-011 o_flag  output  1  one-cycle strobe marking odata valid; feeds the filter chain i_flag.
REQ-012 overrun  output  1  one-cycle pulse when a tick arrives while a conversion is busy.

Function
REQ-013 Free-running tick counter counts 0..SAMPLE_DIV-1 and wraps; the tick is the cycle where count = SAMPLE_DIV-1; it runs regardless of en.
REQ-014 States: IDLE, SETUP, SHIFT, DONE; all outputs registered.
REQ-015 IDLE -> SETUP on tick with en=1; tick with en=0 is ignored, no overrun.
REQ-016 Tick at cycle T: adc_cs_n falls at T+1; SETUP holds for CS_SETUP cycles.
REQ-017 SHIFT: adc_sclk rises at T+1+CS_SETUP+2k*CLK_DIV and falls CLK_DIV cycles later, k=0..7, so exactly 8 pulses.
REQ-018 adc_sdo is sampled on the Clk cycle of each adc_sclk rise and shifted in MSB first.
REQ-019 DONE: at T+2+CS_SETUP+15*CLK_DIV, adc_cs_n = 1, odata = shifted byte, o_flag = 1 for exactly one cycle; then IDLE.
REQ-020 odata holds its value between strobes.
REQ-021 Tick in SETUP, SHIFT or DONE: tick dropped, overrun = 1 on the following cycle, conversion unaffected.
REQ-022 en falling mid-conversion: current conversion completes and strobes; no new conversion starts.
REQ-023 Tick coinciding with DONE counts as busy (REQ-021).

Reset
REQ-024 Rst=1 at any edge: state IDLE, tick counter 0, adc_cs_n=1, adc_sclk=0, odata=0, o_flag=0, overrun=0, shift register and accumulator 0, all effective next cycle.
REQ-025 Reset mid-SHIFT aborts the conversion: no o_flag, no partial odata; first tick after release occurs SAMPLE_DIV cycles after Rst falls.

Configuration
REQ-026 Macro ADC_AVG_EN defined: each conversion adds to a 10-bit accumulator; on every 4th conversion odata = accumulator[9:2], o_flag pulses and the accumulator clears; conversions 1-3 produce no o_flag.
REQ-027 Reset and en falling both clear the accumulator and the conversion count.
REQ-028 ADC_AVG_EN undefined: no accumulator logic; every conversion strobes per REQ-019.

Verification (CLK_DIV=2, CS_SETUP=4, SAMPLE_DIV=64 unless noted)
REQ-029 en=1, ADC model returns 0xA5 -> adc_cs_n low 1 cycle after tick, 8 sclk pulses of period 4, o_flag 36 cycles after tick, odata=0xA5, cs_n high in the same cycle.
REQ-030 Samples 0x00, 0xFF, 0x5A on consecutive ticks -> three o_flag pulses exactly 64 cycles apart with matching odata.
REQ-031 SAMPLE_DIV=20 (illegal, forces overlap) -> overrun pulses the cycle after the tick falling inside busy; conversion byte still correct.
REQ-032 Rst for 1 cycle mid-SHIFT -> cs_n=1, sclk=0, odata=0 next cycle; no o_flag; next cs_n fall 65 cycles after Rst release.
REQ-033 en dropped during SETUP -> that conversion strobes; no cs_n activity on later ticks.
REQ-034 ADC_AVG_EN, samples 10, 20, 30, 41 -> single o_flag after the 4th conversion, odata=25.
